// File: rtl/barrel_shift_arbiter.sv
// barrel_shift_arbiter
// Shares a single combinational barrel shifter between two requesters. Each
// requester offers (operand, shift amount) on a valid/ready channel; a
// round-robin arbiter picks one, the operands are presented to the shifter for
// one cycle, and the registered result is returned on a valid/ready response
// channel tagged with the id of the requester that owns it.
//
// Ports
//   clk, rst                     clock (rising edge), async active-high reset
//   reqN_valid/num/shift/ready   request channel of requester N (N = 0, 1)
//   sh_num, sh_shift             operands driven to the shared shifter
//   sh_ans                       combinational result from the shifter
//   rsp_valid/data/id/ready      response channel
//   busy                         high whenever the FSM is not idle
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | arbitrating; reqN_ready reflects the current grant
// S_SHIFT | latched operands on sh_*, result captured at the clock edge
// S_RESP  | rsp_valid high, held until the consumer takes the result
module barrel_shift_arbiter #(
  parameter int WIDTH = 8,
  parameter int SHW   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_num,
  input  logic [SHW-1:0]   req0_shift,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_num,
  input  logic [SHW-1:0]   req1_shift,
  output logic             req1_ready,
  output logic [WIDTH-1:0] sh_num,
  output logic [SHW-1:0]   sh_shift,
  input  logic [WIDTH-1:0] sh_ans,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_id,
  input  logic             rsp_ready,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_last_grant;
  logic [WIDTH-1:0] r_num;
  logic [SHW-1:0]   r_shift;
  logic             r_id;
  logic [WIDTH-1:0] r_rsp_data;
  logic             r_rsp_id;
  logic             r_rsp_valid;

  logic w_idle;
  logic w_grant0;
  logic w_grant1;

  // Readies are masked while rst is high so every output reads 0 in reset,
  // even if a requester is already presenting valid.
  assign w_idle = (r_state == S_IDLE) && !rst;

  // Round robin: when both are valid, the one that did not win last time goes.
  assign w_grant0 = w_idle && req0_valid && (!req1_valid || r_last_grant);
  assign w_grant1 = w_idle && req1_valid && (!req0_valid || !r_last_grant);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_num        <= '0;
      r_shift      <= '0;
      r_id         <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_id     <= 1'b0;
      r_rsp_valid  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant0 || w_grant1) begin
            r_num        <= w_grant1 ? req1_num : req0_num;
            r_shift      <= w_grant1 ? req1_shift : req0_shift;
            r_id         <= w_grant1;
            r_last_grant <= w_grant1;
            r_state      <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_rsp_data  <= sh_ans;
          r_rsp_id    <= r_id;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  // Shifter operands come only from the latched copy, so they change only on
  // an accepted request.
  assign sh_num     = r_num;
  assign sh_shift   = r_shift;
  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_data   = r_rsp_data;
  assign rsp_id     = r_rsp_id;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_barrel_shift_arbiter.sv
module tb_barrel_shift_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_num, req1_num;
  logic [3:0] req0_shift, req1_shift;
  logic       req0_ready, req1_ready;
  logic [7:0] sh_num;
  logic [3:0] sh_shift;
  logic [7:0] sh_ans;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_id;
  logic       rsp_ready;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: who won last, whether the block should be free to
  // accept, and the responses still owed (id in bit 8, data below).
  logic       model_last;
  logic       model_idle;
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  // Rotate-left shifter stub; only the low 3 bits of the amount matter.
  function automatic logic [7:0] rotl(input logic [7:0] v, input logic [3:0] s);
    logic [15:0] d;
    d = {v, v} << s[2:0];
    return d[15:8];
  endfunction

  assign sh_ans = rotl(sh_num, sh_shift);

  barrel_shift_arbiter #(.WIDTH(8), .SHW(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_num(req0_num), .req0_shift(req0_shift), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_num(req1_num), .req1_shift(req1_shift), .req1_ready(req1_ready),
    .sh_num(sh_num), .sh_shift(sh_shift), .sh_ans(sh_ans),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_ready(rsp_ready),
    .busy(busy)
  );

  task automatic test_reset;
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_num = 8'h00; req1_num = 8'h00; req0_shift = 4'h0; req1_shift = 4'h0;
    rsp_ready = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    n_cmp++; if (req0_ready !== 1'b0) begin n_err++; $display("FAIL reset_req0_ready got=%b exp=0", req0_ready); end
    n_cmp++; if (req1_ready !== 1'b0) begin n_err++; $display("FAIL reset_req1_ready got=%b exp=0", req1_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    n_cmp++; if (rsp_data !== 8'h00) begin n_err++; $display("FAIL reset_rsp_data got=%h exp=00", rsp_data); end
    n_cmp++; if (rsp_id !== 1'b0) begin n_err++; $display("FAIL reset_rsp_id got=%b exp=0", rsp_id); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (sh_num !== 8'h00 || sh_shift !== 4'h0) begin n_err++; $display("FAIL reset_sh got=%h/%h exp=00/0", sh_num, sh_shift); end
    @(negedge clk);
    rst = 1'b0;
    model_last = 1'b1;
    model_idle = 1'b1;
  endtask

  task automatic test_single;
    logic [7:0] exp_d;
    req0_valid = 1'b1; req0_num = 8'hAA; req0_shift = 4'd5; rsp_ready = 1'b1;
    exp_d = rotl(8'hAA, 4'd5);
    #1;
    n_cmp++; if (req0_ready !== 1'b1) begin n_err++; $display("FAIL single_req0_ready got=%b exp=1", req0_ready); end
    n_cmp++; if (req1_ready !== 1'b0) begin n_err++; $display("FAIL single_req1_ready got=%b exp=0", req1_ready); end
    model_last = 1'b0;
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy got=%b exp=1", busy); end
    n_cmp++; if (sh_num !== 8'hAA || sh_shift !== 4'd5) begin n_err++; $display("FAIL single_sh got=%h/%h exp=aa/5", sh_num, sh_shift); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_early_valid got=%b exp=0", rsp_valid); end
    @(negedge clk); #1;
    n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL single_rsp_valid got=%b exp=1", rsp_valid); end
    n_cmp++; if (rsp_data !== exp_d) begin n_err++; $display("FAIL single_rsp_data got=%h exp=%h", rsp_data, exp_d); end
    n_cmp++; if (rsp_id !== 1'b0) begin n_err++; $display("FAIL single_rsp_id got=%b exp=0", rsp_id); end
    @(negedge clk); #1;
    n_cmp++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL single_release got=%b/%b exp=0/0", rsp_valid, busy); end
    @(negedge clk);
  endtask

  task automatic test_round_robin;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_last = 1'b1;
    req0_num = 8'($urandom); req0_shift = 4'($urandom);
    req1_num = 8'($urandom); req1_shift = 4'($urandom);
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    for (int r = 0; r < 4; r++) begin
      int got;
      logic exp_g;
      logic [7:0] exp_d;
      exp_g = !model_last;
      exp_d = exp_g ? rotl(req1_num, req1_shift) : rotl(req0_num, req0_shift);
      got = -1;
      for (int c = 0; c < 8; c++) begin
        #1;
        if (req0_ready || req1_ready) begin
          got = req1_ready ? 1 : 0;
          n_cmp++; if (req0_ready && req1_ready) begin n_err++; $display("FAIL rr_both_ready round=%0d got=11 exp=one", r); end
          break;
        end
        @(negedge clk);
      end
      n_cmp++; if (got != int'(exp_g)) begin n_err++; $display("FAIL rr_grant round=%0d got=%0d exp=%0d", r, got, exp_g); end
      model_last = exp_g;
      @(negedge clk);
      if (exp_g) begin req1_num = 8'($urandom); req1_shift = 4'($urandom); end
      else begin req0_num = 8'($urandom); req0_shift = 4'($urandom); end
      for (int c = 0; c < 6; c++) begin
        #1;
        if (rsp_valid) break;
        @(negedge clk);
      end
      n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL rr_rsp_timeout round=%0d got=%b exp=1", r, rsp_valid); end
      n_cmp++; if (rsp_id !== exp_g) begin n_err++; $display("FAIL rr_rsp_id round=%0d got=%b exp=%b", r, rsp_id, exp_g); end
      n_cmp++; if (rsp_data !== exp_d) begin n_err++; $display("FAIL rr_rsp_data round=%0d got=%h exp=%h", r, rsp_data, exp_d); end
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    logic [7:0] exp_d;
    req1_valid = 1'b1; req1_num = 8'h81; req1_shift = 4'd1; rsp_ready = 1'b0;
    #1;
    n_cmp++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin n_err++; $display("FAIL bp_accept got=%b%b exp=10", req1_ready, req0_ready); end
    model_last = 1'b1;
    @(negedge clk);
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_num = 8'($urandom); req0_shift = 4'($urandom);
    #1;
    n_cmp++; if (sh_num !== 8'h81 || sh_shift !== 4'd1) begin n_err++; $display("FAIL bp_sh got=%h/%h exp=81/1", sh_num, sh_shift); end
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      #1;
      n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold_valid cyc=%0d got=%b exp=1", k, rsp_valid); end
      n_cmp++; if (rsp_data !== 8'h03 || rsp_id !== 1'b1) begin n_err++; $display("FAIL bp_hold_data cyc=%0d got=%h/%b exp=03/1", k, rsp_data, rsp_id); end
      n_cmp++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin n_err++; $display("FAIL bp_hold_ready cyc=%0d got=%b%b exp=00", k, req0_ready, req1_ready); end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    n_cmp++; if (rsp_valid !== 1'b1 || req0_ready !== 1'b0) begin n_err++; $display("FAIL bp_release got=%b/%b exp=1/0", rsp_valid, req0_ready); end
    @(negedge clk); #1;
    n_cmp++; if (rsp_valid !== 1'b0 || req0_ready !== 1'b1) begin n_err++; $display("FAIL bp_next_accept got=%b/%b exp=0/1", rsp_valid, req0_ready); end
    model_last = 1'b0;
    exp_d = rotl(req0_num, req0_shift);
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk); #1;
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_data !== exp_d || rsp_id !== 1'b0) begin n_err++; $display("FAIL bp_req0_rsp got=%b/%h/%b exp=1/%h/0", rsp_valid, rsp_data, rsp_id, exp_d); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    logic [7:0] exp_d;
    req0_valid = 1'b1; req0_num = 8'hF0; req0_shift = 4'($urandom_range(0, 15)); rsp_ready = 1'b1;
    #1;
    n_cmp++; if (req0_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_accept got=%b exp=1", req0_ready); end
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rstmid_busy got=%b exp=1", busy); end
    rst = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_data !== 8'h00 || rsp_id !== 1'b0) begin n_err++; $display("FAIL rstmid_outputs got=%b/%b/%h/%b exp=0/0/00/0", busy, rsp_valid, rsp_data, rsp_id); end
    n_cmp++; if (sh_num !== 8'h00 || sh_shift !== 4'h0) begin n_err++; $display("FAIL rstmid_sh got=%h/%h exp=00/0", sh_num, sh_shift); end
    @(negedge clk);
    rst = 1'b0;
    model_last = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_cmp++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL rstmid_no_rsp cyc=%0d got=%b/%b exp=0/0", k, rsp_valid, busy); end
      @(negedge clk);
    end
    req0_valid = 1'b1; req0_num = 8'($urandom); req0_shift = 4'($urandom);
    req1_valid = 1'b1; req1_num = 8'($urandom); req1_shift = 4'($urandom);
    #1;
    n_cmp++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin n_err++; $display("FAIL rstmid_priority got=%b%b exp=10", req0_ready, req1_ready); end
    model_last = 1'b0;
    exp_d = rotl(req0_num, req0_shift);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk); #1;
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_data !== exp_d || rsp_id !== 1'b0) begin n_err++; $display("FAIL rstmid_rsp got=%b/%h/%b exp=1/%h/0", rsp_valid, rsp_data, rsp_id, exp_d); end
    @(negedge clk);
  endtask

  task automatic test_large_shift;
    req1_valid = 1'b1; req1_num = 8'h3C; req1_shift = 4'd8; rsp_ready = 1'b1;
    #1;
    n_cmp++; if (req1_ready !== 1'b1) begin n_err++; $display("FAIL large_accept got=%b exp=1", req1_ready); end
    model_last = 1'b1;
    @(negedge clk);
    req1_valid = 1'b0;
    #1;
    n_cmp++; if (sh_shift !== 4'd8 || sh_num !== 8'h3C) begin n_err++; $display("FAIL large_sh got=%h/%h exp=3c/8", sh_num, sh_shift); end
    @(negedge clk); #1;
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h3C || rsp_id !== 1'b1) begin n_err++; $display("FAIL large_rsp got=%b/%h/%b exp=1/3c/1", rsp_valid, rsp_data, rsp_id); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int last_c;
    int pulses;
    logic acc;
    logic [8:0] e;
    exp_q.delete();
    last_c = -1; pulses = 0;
    req0_valid = 1'b1; req0_num = 8'($urandom); req0_shift = 4'($urandom); rsp_ready = 1'b1;
    for (int c = 0; c < 30 && pulses < 4; c++) begin
      #1;
      acc = req0_ready;
      if (rsp_valid && rsp_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL b2b_extra_rsp cyc=%0d got=%h exp=none", c, rsp_data); end
        else begin
          e = exp_q.pop_front();
          if ({rsp_id, rsp_data} !== e) begin n_err++; $display("FAIL b2b_rsp cyc=%0d got=%b/%h exp=%b/%h", c, rsp_id, rsp_data, e[8], e[7:0]); end
        end
      end
      if (acc) begin
        if (last_c >= 0) begin
          n_cmp++; if (c - last_c != 3) begin n_err++; $display("FAIL b2b_gap got=%0d exp=3", c - last_c); end
        end
        last_c = c;
        pulses++;
        exp_q.push_back({1'b0, rotl(req0_num, req0_shift)});
        model_last = 1'b0;
      end
      @(negedge clk);
      if (acc) begin req0_num = 8'($urandom); req0_shift = 4'($urandom); end
    end
    req0_valid = 1'b0;
    n_cmp++; if (pulses != 4) begin n_err++; $display("FAIL b2b_pulses got=%0d exp=4", pulses); end
    for (int c = 0; c < 6 && exp_q.size() > 0; c++) begin
      #1;
      if (rsp_valid) begin
        e = exp_q.pop_front();
        n_cmp++; if ({rsp_id, rsp_data} !== e) begin n_err++; $display("FAIL b2b_last_rsp got=%b/%h exp=%b/%h", rsp_id, rsp_data, e[8], e[7:0]); end
      end
      @(negedge clk);
    end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL b2b_drain got=%0d exp=0", exp_q.size()); end
    exp_q.delete();
    @(negedge clk);
  endtask

  task automatic test_random;
    logic exp_r0, exp_r1, clr0, clr1;
    logic [8:0] e;
    model_idle = 1'b1;
    exp_q.delete();
    clr0 = 1'b0; clr1 = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (clr0) req0_valid = 1'b0;
      if (clr1) req1_valid = 1'b0;
      clr0 = 1'b0; clr1 = 1'b0;
      if (c < 380) begin
        if (!req0_valid && $urandom_range(0, 1) == 1) begin
          req0_valid = 1'b1; req0_num = 8'($urandom); req0_shift = 4'($urandom);
        end
        if (!req1_valid && $urandom_range(0, 1) == 1) begin
          req1_valid = 1'b1; req1_num = 8'($urandom); req1_shift = 4'($urandom);
        end
        rsp_ready = ($urandom_range(0, 3) != 0);
      end else begin
        rsp_ready = 1'b1;
      end
      #1;
      exp_r0 = model_idle && req0_valid && (!req1_valid || model_last);
      exp_r1 = model_idle && req1_valid && (!req0_valid || !model_last);
      n_cmp++; if (req0_ready !== exp_r0 || req1_ready !== exp_r1) begin n_err++; $display("FAIL rand_ready cyc=%0d got=%b%b exp=%b%b", c, req0_ready, req1_ready, exp_r0, exp_r1); end
      if (rsp_valid) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL rand_spurious_rsp cyc=%0d got=%h exp=none", c, rsp_data); end
        else if ({rsp_id, rsp_data} !== exp_q[0]) begin n_err++; $display("FAIL rand_rsp cyc=%0d got=%b/%h exp=%b/%h", c, rsp_id, rsp_data, exp_q[0][8], exp_q[0][7:0]); end
        if (rsp_ready && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          model_idle = 1'b1;
        end
      end
      if (exp_r0) begin
        exp_q.push_back({1'b0, rotl(req0_num, req0_shift)});
        model_last = 1'b0; model_idle = 1'b0; clr0 = 1'b1;
      end else if (exp_r1) begin
        exp_q.push_back({1'b1, rotl(req1_num, req1_shift)});
        model_last = 1'b1; model_idle = 1'b0; clr1 = 1'b1;
      end
      @(negedge clk);
      if (c >= 380 && exp_q.size() == 0 && !req0_valid && !req1_valid) break;
    end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL rand_drain got=%0d exp=0", exp_q.size()); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_large_shift();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
